// File: rtl/skew_delay_line.sv
// Multi-channel delay line with a runtime-programmable latency (0..MAX_DELAY cycles) per channel.
// Define SKEW_DELAY_LINE_HOLD_EN to hold the last valid out_data while out_valid is low.
module skew_delay_line #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_DELAY = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]      cfg_ch,
  input  logic [$clog2(MAX_DELAY + 1)-1:0]                    cfg_delay,
  input  logic [NUM_CH-1:0]                                   in_valid,
  input  logic [NUM_CH*WIDTH-1:0]                             in_data,
  output logic [NUM_CH-1:0]                                   out_valid,
  output logic [NUM_CH*WIDTH-1:0]                             out_data,
  output logic                                                cfg_err
);

  localparam int unsigned DW = $clog2(MAX_DELAY + 1);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DW-1:0] LP_MAX_DELAY = DW'(MAX_DELAY);
  localparam logic [CW:0]   LP_NUM_CH    = (CW + 1)'(NUM_CH);

  logic w_cfg_fields_ok;
  logic w_cfg_ok;
  logic r_cfg_err;

  assign w_cfg_fields_ok = ({1'b0, cfg_ch} < LP_NUM_CH) && (cfg_delay <= LP_MAX_DELAY);
  assign w_cfg_ok        = cfg_we && w_cfg_fields_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else if (cfg_we && !w_cfg_fields_ok) begin
      r_cfg_err <= 1'b1;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DW-1:0]        r_delay;
    logic [MAX_DELAY-1:0] r_vld;
    logic [WIDTH-1:0]     r_dat [MAX_DELAY];
    logic                 w_flush;
    logic                 w_vld;
    logic [WIDTH-1:0]     w_dat;

    assign w_flush = w_cfg_ok && (cfg_ch == CW'(c));

    // A flush clears older stages only; the sample arriving at the write edge is kept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_delay <= DW'(1);
        r_vld   <= '0;
        for (int s = 0; s < int'(MAX_DELAY); s++) begin
          r_dat[s] <= '0;
        end
      end else begin
        if (w_flush) begin
          r_delay <= cfg_delay;
        end
        r_vld[0] <= in_valid[c];
        r_dat[0] <= in_data[c*WIDTH +: WIDTH];
        for (int s = 1; s < int'(MAX_DELAY); s++) begin
          r_vld[s] <= r_vld[s-1] & ~w_flush;
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    // Delay 0 bypasses the pipeline; delay D selects stage D-1.
    always_comb begin
      w_vld = in_valid[c];
      w_dat = in_data[c*WIDTH +: WIDTH];
      for (int s = 0; s < int'(MAX_DELAY); s++) begin
        if (r_delay == DW'(s + 1)) begin
          w_vld = r_vld[s];
          w_dat = r_dat[s];
        end
      end
    end

    assign out_valid[c] = w_vld;

`ifdef SKEW_DELAY_LINE_HOLD_EN
    logic [WIDTH-1:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
      end else if (w_vld) begin
        r_hold <= w_dat;
      end
    end

    assign out_data[c*WIDTH +: WIDTH] = w_vld ? w_dat : r_hold;
`else
    assign out_data[c*WIDTH +: WIDTH] = w_vld ? w_dat : '0;
`endif
  end

endmodule
